// File: rtl/dm_arbiter.sv
// dm_arbiter: shares the single data-memory (dm) BRAM port between the CPU
// M stage and the DMA/loader port. One access is issued per cycle. Read data
// comes back on the BRAM's one-cycle latency. Writes with illegal byte-enable
// patterns are granted but blocked from the memory and flagged on be_err.
//
// Ports:
//   Clk, Reset                       clock, synchronous active-high reset
//   cpu_req/we/addr/be/wdata         CPU request side
//   cpu_gnt, cpu_rvalid, cpu_rdata   CPU grant and read return
//   dma_req/we/addr/be/wdata         DMA request side
//   dma_gnt, dma_rvalid, dma_rdata   DMA grant and read return
//   dm_Addr, dm_Din, dm_Be, dm_We    drive the dm BRAM
//   dm_Dout                          dm read data, one cycle after address
//   be_err                           pulse one cycle after an illegal-be write
module dm_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [3:0]  cpu_be,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [3:0]  dma_be,
  input  logic [31:0] dma_wdata,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [31:0] dma_rdata,
  output logic [31:0] dm_Addr,
  output logic [31:0] dm_Din,
  output logic [3:0]  dm_Be,
  output logic        dm_We,
  input  logic [31:0] dm_Dout,
  output logic        be_err
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_CPU  = 2'd1,
    RD_DMA  = 2'd2
  } rd_owner_t;

  logic [7:0] starve_cnt_q, starve_cnt_d;
  rd_owner_t  rd_owner_q, rd_owner_d;
  logic       be_err_q, be_err_d;

  logic       force_dma;
  logic       sel_we;
  logic [3:0] sel_be;
  logic       be_legal;
  logic       granted;

  always_comb begin
    force_dma = (starve_cnt_q == LIMIT);
    cpu_gnt   = 1'b0;
    dma_gnt   = 1'b0;
    if (!Reset) begin
      if (force_dma && dma_req) begin
        dma_gnt = 1'b1;
      end else if (cpu_req) begin
        cpu_gnt = 1'b1;
      end else if (dma_req) begin
        dma_gnt = 1'b1;
      end
    end
  end

  // Address/data default to the CPU side when idle; be is masked to zero.
  always_comb begin
    granted = cpu_gnt | dma_gnt;
    dm_Addr = dma_gnt ? dma_addr  : cpu_addr;
    dm_Din  = dma_gnt ? dma_wdata : cpu_wdata;
    sel_be  = dma_gnt ? dma_be    : cpu_be;
    sel_we  = dma_gnt ? dma_we    : cpu_we;
    dm_Be   = granted ? sel_be : '0;

    case (sel_be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: be_legal = 1'b1;
      default:                   be_legal = 1'b0;
    endcase

    dm_We    = granted & sel_we & be_legal;
    be_err_d = granted & sel_we & ~be_legal;
  end

  always_comb begin
    if (dma_gnt || !dma_req) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q < LIMIT) begin
      starve_cnt_d = starve_cnt_q + 8'd1;
    end else begin
      starve_cnt_d = starve_cnt_q;
    end

    rd_owner_d = RD_NONE;
    if (cpu_gnt && !cpu_we) begin
      rd_owner_d = RD_CPU;
    end else if (dma_gnt && !dma_we) begin
      rd_owner_d = RD_DMA;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      starve_cnt_q <= '0;
      rd_owner_q   <= RD_NONE;
      be_err_q     <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rd_owner_q   <= rd_owner_d;
      be_err_q     <= be_err_d;
    end
  end

  // Gating with Reset suppresses a return still in flight when reset lands
  // in the cycle right after the read grant.
  always_comb begin
    cpu_rvalid = (rd_owner_q == RD_CPU) && !Reset;
    dma_rvalid = (rd_owner_q == RD_DMA) && !Reset;
    cpu_rdata  = cpu_rvalid ? dm_Dout : '0;
    dma_rdata  = dma_rvalid ? dm_Dout : '0;
    be_err     = be_err_q;
  end

endmodule

// File: tb/tb_dm_arbiter.sv
module tb_dm_arbiter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [3:0]  cpu_be;
  logic        cpu_gnt, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        dma_req, dma_we;
  logic [31:0] dma_addr, dma_wdata;
  logic [3:0]  dma_be;
  logic        dma_gnt, dma_rvalid;
  logic [31:0] dma_rdata;
  logic [31:0] dm_Addr, dm_Din, dm_Dout;
  logic [3:0]  dm_Be;
  logic        dm_We;
  logic        be_err;

  int n_total = 0;
  int n_pass  = 0;

  always #5 Clk = ~Clk;

  dm_arbiter #(.STARVE_LIMIT(8)) dut (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_be(cpu_be),
    .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_be(dma_be),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
    .dma_rdata(dma_rdata),
    .dm_Addr(dm_Addr), .dm_Din(dm_Din), .dm_Be(dm_Be), .dm_We(dm_We),
    .dm_Dout(dm_Dout), .be_err(be_err)
  );

  // Byte-enabled BRAM model, write-first, low-aligned write data steered
  // onto the enabled lanes.
  logic [31:0] mem [0:63];

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] din,
                                        input logic [3:0]  be);
    logic [31:0] r;
    r = old;
    case (be)
      4'b0001: r[7:0]   = din[7:0];
      4'b0010: r[15:8]  = din[7:0];
      4'b0100: r[23:16] = din[7:0];
      4'b1000: r[31:24] = din[7:0];
      4'b0011: r[15:0]  = din[15:0];
      4'b1100: r[31:16] = din[15:0];
      4'b1111: r        = din;
      default: r        = old;
    endcase
    return r;
  endfunction

  always @(posedge Clk) begin
    if (dm_We) begin
      mem[dm_Addr[5:0]] <= merge(mem[dm_Addr[5:0]], dm_Din, dm_Be);
      dm_Dout           <= merge(mem[dm_Addr[5:0]], dm_Din, dm_Be);
    end else begin
      dm_Dout <= mem[dm_Addr[5:0]];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic cpu(input logic req, input logic we, input logic [31:0] addr,
                     input logic [3:0] be, input logic [31:0] wdata);
    cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_be = be; cpu_wdata = wdata;
  endtask

  task automatic dma(input logic req, input logic we, input logic [31:0] addr,
                     input logic [3:0] be, input logic [31:0] wdata);
    dma_req = req; dma_we = we; dma_addr = addr; dma_be = be; dma_wdata = wdata;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic mid();
    @(negedge Clk);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[16] = 32'h1234_5678;
    mem[17] = 32'hCAFE_F00D;

    // Reset with both requesters active and a write pending
    Reset = 1'b1;
    cpu(1'b1, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF);
    dma(1'b1, 1'b1, 32'h11, 4'hF, 32'hDEAD_BEEF);
    step(); mid();
    check("rst_cpu_gnt", {31'd0, cpu_gnt}, 32'd0);
    check("rst_dma_gnt", {31'd0, dma_gnt}, 32'd0);
    check("rst_dm_we",   {31'd0, dm_We},   32'd0);
    step();
    Reset = 1'b0;
    cpu(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    dma(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    mid();
    check("rst_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    check("rst_dma_rvalid", {31'd0, dma_rvalid}, 32'd0);
    check("rst_cpu_rdata", cpu_rdata, 32'd0);
    check("rst_be_err", {31'd0, be_err}, 32'd0);
    check("idle_dm_be", {28'd0, dm_Be}, 32'd0);

    // CPU read of preloaded word
    step();
    cpu(1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
    mid();
    check("rd_cpu_gnt", {31'd0, cpu_gnt}, 32'd1);
    check("rd_dma_gnt", {31'd0, dma_gnt}, 32'd0);
    check("rd_dm_we",   {31'd0, dm_We},   32'd0);
    check("rd_dm_addr", dm_Addr, 32'h10);
    step();
    cpu(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    mid();
    check("rd_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd1);
    check("rd_cpu_rdata", cpu_rdata, 32'h1234_5678);
    check("rd_dma_rvalid", {31'd0, dma_rvalid}, 32'd0);
    check("rd_dma_rdata", dma_rdata, 32'd0);

    // Byte write then back-to-back read
    step();
    cpu(1'b1, 1'b1, 32'h20, 4'b0010, 32'h0000_00AB);
    mid();
    check("bw_gnt", {31'd0, cpu_gnt}, 32'd1);
    check("bw_dm_we", {31'd0, dm_We}, 32'd1);
    check("bw_dm_be", {28'd0, dm_Be}, 32'h2);
    check("bw_dm_din", dm_Din, 32'h0000_00AB);
    step();
    cpu(1'b1, 1'b0, 32'h20, 4'hF, 32'h0);
    mid();
    check("bw_no_be_err", {31'd0, be_err}, 32'd0);
    step();
    cpu(1'b1, 1'b1, 32'h20, 4'b1100, 32'h0000_BEEF);
    mid();
    check("bw_rd_data", cpu_rdata, 32'h0000_AB00);
    check("hw_dm_we", {31'd0, dm_We}, 32'd1);
    step();
    cpu(1'b1, 1'b0, 32'h20, 4'hF, 32'h0);
    mid();
    step();
    // Illegal byte-enable write: granted, memory untouched
    cpu(1'b1, 1'b1, 32'h20, 4'b0101, 32'hFFFF_FFFF);
    mid();
    check("hw_rd_data", cpu_rdata, 32'hBEEF_AB00);
    check("ill_gnt", {31'd0, cpu_gnt}, 32'd1);
    check("ill_dm_we", {31'd0, dm_We}, 32'd0);
    step();
    cpu(1'b1, 1'b0, 32'h20, 4'b0101, 32'h0);
    mid();
    check("ill_be_err", {31'd0, be_err}, 32'd1);
    check("rd_ill_be_dm_we", {31'd0, dm_We}, 32'd0);
    step();
    cpu(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    mid();
    check("ill_readback", cpu_rdata, 32'hBEEF_AB00);
    check("ill_be_err_clr", {31'd0, be_err}, 32'd0);

    // DMA write and readback on the DMA port
    step();
    dma(1'b1, 1'b1, 32'h30, 4'b0011, 32'h0000_1234);
    mid();
    check("dw_gnt", {31'd0, dma_gnt}, 32'd1);
    check("dw_dm_addr", dm_Addr, 32'h30);
    step();
    dma(1'b1, 1'b0, 32'h30, 4'hF, 32'h0);
    step();
    dma(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    mid();
    check("dw_rvalid", {31'd0, dma_rvalid}, 32'd1);
    check("dw_rdata", dma_rdata, 32'h0000_1234);
    check("dw_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);

    // Starvation: both ports requesting continuously
    step();
    cpu(1'b1, 1'b0, 32'h0, 4'hF, 32'h0);
    dma(1'b1, 1'b0, 32'h4, 4'hF, 32'h0);
    for (int c = 1; c <= 18; c++) begin
      mid();
      check($sformatf("starve_dma_c%0d", c), {31'd0, dma_gnt}, {31'd0, (c % 9) == 0});
      check($sformatf("starve_cpu_c%0d", c), {31'd0, cpu_gnt}, {31'd0, (c % 9) != 0});
      step();
    end
    cpu(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    dma(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    step();

    // Interleaved reads, alternating ports
    for (int r = 0; r < 2; r++) begin
      cpu(1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
      mid();
      check("il_cpu_gnt", {31'd0, cpu_gnt}, 32'd1);
      step();
      cpu(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      dma(1'b1, 1'b0, 32'h11, 4'hF, 32'h0);
      mid();
      check("il_dma_gnt", {31'd0, dma_gnt}, 32'd1);
      check("il_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd1);
      check("il_cpu_rdata", cpu_rdata, 32'h1234_5678);
      check("il_dma_rdata0", dma_rdata, 32'd0);
      step();
      dma(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      mid();
      check("il_dma_rvalid", {31'd0, dma_rvalid}, 32'd1);
      check("il_dma_rdata", dma_rdata, 32'hCAFE_F00D);
      check("il_cpu_rvalid0", {31'd0, cpu_rvalid}, 32'd0);
      check("il_cpu_rdata0", cpu_rdata, 32'd0);
      step();
    end

    // Reset mid-read with the starvation counter part-way up
    cpu(1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
    dma(1'b1, 1'b0, 32'h11, 4'hF, 32'h0);
    for (int c = 0; c < 5; c++) step();
    Reset = 1'b1;
    mid();
    check("mr_cpu_gnt", {31'd0, cpu_gnt}, 32'd0);
    check("mr_dma_gnt", {31'd0, dma_gnt}, 32'd0);
    check("mr_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    step();
    Reset = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      mid();
      if (c == 1) check("mr_cpu_rvalid_after", {31'd0, cpu_rvalid}, 32'd0);
      check($sformatf("mr_starve_dma_c%0d", c), {31'd0, dma_gnt}, {31'd0, c == 9});
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
